// File: rtl/rob_superscalar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_superscalar_pkg
// Description : Shared sizing constants, entry/lane structs and helpers for
//               the N-way reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_superscalar_pkg;

  localparam int NUM_ROB    = 32;
  localparam int DISPATCH_W = 2;
  localparam int RETIRE_W   = 2;
  localparam int CDB_W      = 2;
  localparam int PR_W       = 6;
  localparam int AR_W       = 5;

  localparam int IDX_W = $clog2(NUM_ROB);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic            halt;
    logic [AR_W-1:0] dest_idx;
    logic [PR_W-1:0] T_idx;
    logic [PR_W-1:0] Told_idx;
  } ROB_ENTRY_t;

  typedef ROB_ENTRY_t [NUM_ROB-1:0] ROB_t;

  typedef struct packed {
    logic            halt;
    logic [AR_W-1:0] dest_idx;
    logic [PR_W-1:0] T_idx;
    logic [PR_W-1:0] Told_idx;
  } ROB_DISPATCH_IN_t;

  typedef struct packed {
    logic [AR_W-1:0] dest_idx;
    logic [PR_W-1:0] T_idx;
    logic [PR_W-1:0] Told_idx;
  } ROB_RETIRE_OUT_t;

  // Number of set bits in a lane-valid vector (caller zero-extends to 32).
  function automatic logic [CNT_W-1:0] popcnt(input logic [31:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int b = 0; b < 32; b++) begin
      n = n + CNT_W'(v[b]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_superscalar_retire_sel.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_sel
// Description : Picks the contiguous run of valid+complete entries starting at
//               the head, stopping after the first halt entry.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_retire_sel
  import rob_superscalar_pkg::*;
(
  input  ROB_ENTRY_t [RETIRE_W-1:0] head_entries_i,
  input  logic                      allow_i,
  output logic [RETIRE_W-1:0]       retire_en_o,
  output logic                      halt_o,
  output logic [CNT_W-1:0]          retire_cnt_o
);

  logic blocked;

  // Walk head lanes in age order; the first not-ready or halt entry ends the group
  always_comb begin
    retire_en_o  = '0;
    halt_o       = 1'b0;
    retire_cnt_o = '0;
    blocked      = ~allow_i;
    for (int j = 0; j < RETIRE_W; j++) begin
      if (!blocked && head_entries_i[j].valid && head_entries_i[j].complete) begin
        retire_en_o[j] = 1'b1;
        retire_cnt_o   = retire_cnt_o + CNT_W'(1);
        if (head_entries_i[j].halt) begin
          halt_o  = 1'b1;
          blocked = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_superscalar.sv
`default_nettype none
// ============================================================================
// Module      : rob_superscalar
// Description : N-way reorder buffer: multi-lane in-order dispatch, CDB
//               completion, multi-lane in-order retire, branch rollback.
//               Optional perf counters enabled by macro ROB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_superscalar
  import rob_superscalar_pkg::*;
(
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic [DISPATCH_W-1:0]        dispatch_en_i,
  input  logic [DISPATCH_W*AR_W-1:0]   dispatch_dest_idx_i,
  input  logic [DISPATCH_W*PR_W-1:0]   dispatch_T_idx_i,
  input  logic [DISPATCH_W*PR_W-1:0]   dispatch_Told_idx_i,
  input  logic [DISPATCH_W-1:0]        dispatch_halt_i,
  output logic                         dispatch_ready_o,
  output logic [DISPATCH_W*IDX_W-1:0]  ROB_idx_o,
  output logic [CNT_W-1:0]             free_slots_o,
  input  logic [CDB_W-1:0]             complete_en_i,
  input  logic [CDB_W*IDX_W-1:0]       complete_idx_i,
  input  logic                         rollback_en_i,
  input  logic [IDX_W-1:0]             rollback_idx_i,
  output logic [RETIRE_W-1:0]          retire_en_o,
  output logic [RETIRE_W*AR_W-1:0]     retire_dest_idx_o,
  output logic [RETIRE_W*PR_W-1:0]     retire_T_idx_o,
  output logic [RETIRE_W*PR_W-1:0]     retire_Told_idx_o,
  output logic                         halt_out_o
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_retired_o,
  output logic [31:0]                  perf_full_stall_o,
  output logic [31:0]                  perf_squashed_o
`endif
);

  ROB_t                             rob_q, rob_d;
  logic [IDX_W-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             halted_q, halted_d;

  ROB_DISPATCH_IN_t [DISPATCH_W-1:0] disp_lane;
  ROB_ENTRY_t [RETIRE_W-1:0]         head_ent;
  ROB_RETIRE_OUT_t [RETIRE_W-1:0]    retire_lane;
  logic [CNT_W-1:0]                  disp_k;
  logic [CNT_W-1:0]                  retire_r;
  logic                              rb_act;
  logic [IDX_W-1:0]                  dist_rb;
  logic [IDX_W-1:0]                  sq_dist;
  logic [IDX_W-1:0]                  cidx;

  genvar gi;
  generate
    for (gi = 0; gi < DISPATCH_W; gi++) begin : g_disp_lane
      assign disp_lane[gi] = '{halt:     dispatch_halt_i[gi],
                               dest_idx: dispatch_dest_idx_i[gi*AR_W +: AR_W],
                               T_idx:    dispatch_T_idx_i[gi*PR_W +: PR_W],
                               Told_idx: dispatch_Told_idx_i[gi*PR_W +: PR_W]};
      assign ROB_idx_o[gi*IDX_W +: IDX_W] = tail_q + IDX_W'(gi);
    end

    for (gi = 0; gi < RETIRE_W; gi++) begin : g_retire_lane
      assign head_ent[gi]    = rob_q[head_q + IDX_W'(gi)];
      assign retire_lane[gi] = '{dest_idx: head_ent[gi].dest_idx,
                                 T_idx:    head_ent[gi].T_idx,
                                 Told_idx: head_ent[gi].Told_idx};
      assign retire_dest_idx_o[gi*AR_W +: AR_W] = retire_lane[gi].dest_idx;
      assign retire_T_idx_o[gi*PR_W +: PR_W]    = retire_lane[gi].T_idx;
      assign retire_Told_idx_o[gi*PR_W +: PR_W] = retire_lane[gi].Told_idx;
    end
  endgenerate

  rob_retire_sel u_retire_sel (
    .head_entries_i (head_ent),
    .allow_i        (en_i & ~halted_q),
    .retire_en_o    (retire_en_o),
    .halt_o         (halt_out_o),
    .retire_cnt_o   (retire_r)
  );

  // Same-cycle retire frees nothing for dispatch, keeping ready off the retire path
  assign disp_k           = popcnt(32'(dispatch_en_i));
  assign free_slots_o     = CNT_W'(NUM_ROB) - count_q;
  assign dispatch_ready_o = en_i & ~rollback_en_i & ~halted_q & (disp_k <= free_slots_o);
  assign rb_act           = en_i & rollback_en_i & rob_q[rollback_idx_i].valid;
  assign dist_rb          = rollback_idx_i - head_q;

  // Next-state: completion, retire clear, dispatch write, then rollback squash (wins)
  always_comb begin
    rob_d    = rob_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;
    sq_dist  = '0;
    cidx     = '0;
    if (en_i) begin
      for (int p = 0; p < CDB_W; p++) begin
        cidx = complete_idx_i[p*IDX_W +: IDX_W];
        if (complete_en_i[p] && rob_q[cidx].valid) begin
          rob_d[cidx].complete = 1'b1;
        end
      end
      for (int j = 0; j < RETIRE_W; j++) begin
        if (retire_en_o[j]) begin
          rob_d[head_q + IDX_W'(j)] = '0;
        end
      end
      if (dispatch_ready_o) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
          if (dispatch_en_i[i]) begin
            rob_d[tail_q + IDX_W'(i)] = '{valid:    1'b1,
                                          complete: 1'b0,
                                          halt:     disp_lane[i].halt,
                                          dest_idx: disp_lane[i].dest_idx,
                                          T_idx:    disp_lane[i].T_idx,
                                          Told_idx: disp_lane[i].Told_idx};
          end
        end
      end
      if (rb_act) begin
        // Age is distance from head; occupancy bounds the live window even when full
        for (int e = 0; e < NUM_ROB; e++) begin
          sq_dist = IDX_W'(e) - head_q;
          if ((sq_dist > dist_rb) && ({1'b0, sq_dist} < count_q)) begin
            rob_d[e] = '0;
          end
        end
        tail_d  = rollback_idx_i + IDX_W'(1);
        count_d = CNT_W'(dist_rb) + CNT_W'(1) - retire_r;
      end else begin
        tail_d  = tail_q + (dispatch_ready_o ? disp_k[IDX_W-1:0] : '0);
        count_d = count_q + (dispatch_ready_o ? disp_k : '0) - retire_r;
      end
      head_d   = head_q + retire_r[IDX_W-1:0];
      halted_d = halted_q | halt_out_o;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rob_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      rob_q    <= rob_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0]      perf_retired_q, perf_full_stall_q, perf_squashed_q;
  logic [CNT_W-1:0] squash_cnt;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign squash_cnt = count_q - CNT_W'(dist_rb) - CNT_W'(1);

  // Saturating event counters, frozen while the ROB is disabled
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      perf_retired_q    <= '0;
      perf_full_stall_q <= '0;
      perf_squashed_q   <= '0;
    end else if (en_i) begin
      perf_retired_q <= sat_add(perf_retired_q, 32'(retire_r));
      if ((|dispatch_en_i) && !dispatch_ready_o) begin
        perf_full_stall_q <= sat_add(perf_full_stall_q, 32'd1);
      end
      if (rb_act) begin
        perf_squashed_q <= sat_add(perf_squashed_q, 32'(squash_cnt));
      end
    end
  end

  assign perf_retired_o    = perf_retired_q;
  assign perf_full_stall_o = perf_full_stall_q;
  assign perf_squashed_o   = perf_squashed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_superscalar.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_superscalar
// Description : Scoreboard bench for rob_superscalar: dispatched entries are
//               queued in program order and compared as they retire, plus
//               directed checks of occupancy, rollback, halt and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_superscalar;
  import rob_superscalar_pkg::*;

  logic                        clock_i = 1'b0;
  logic                        reset_i;
  logic                        en_i;
  logic [DISPATCH_W-1:0]       dispatch_en_i;
  logic [DISPATCH_W*AR_W-1:0]  dispatch_dest_idx_i;
  logic [DISPATCH_W*PR_W-1:0]  dispatch_T_idx_i;
  logic [DISPATCH_W*PR_W-1:0]  dispatch_Told_idx_i;
  logic [DISPATCH_W-1:0]       dispatch_halt_i;
  logic                        dispatch_ready_o;
  logic [DISPATCH_W*IDX_W-1:0] ROB_idx_o;
  logic [CNT_W-1:0]            free_slots_o;
  logic [CDB_W-1:0]            complete_en_i;
  logic [CDB_W*IDX_W-1:0]      complete_idx_i;
  logic                        rollback_en_i;
  logic [IDX_W-1:0]            rollback_idx_i;
  logic [RETIRE_W-1:0]         retire_en_o;
  logic [RETIRE_W*AR_W-1:0]    retire_dest_idx_o;
  logic [RETIRE_W*PR_W-1:0]    retire_T_idx_o;
  logic [RETIRE_W*PR_W-1:0]    retire_Told_idx_o;
  logic                        halt_out_o;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]                 perf_retired_o, perf_full_stall_o, perf_squashed_o;
`endif

  rob_superscalar dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .en_i                (en_i),
    .dispatch_en_i       (dispatch_en_i),
    .dispatch_dest_idx_i (dispatch_dest_idx_i),
    .dispatch_T_idx_i    (dispatch_T_idx_i),
    .dispatch_Told_idx_i (dispatch_Told_idx_i),
    .dispatch_halt_i     (dispatch_halt_i),
    .dispatch_ready_o    (dispatch_ready_o),
    .ROB_idx_o           (ROB_idx_o),
    .free_slots_o        (free_slots_o),
    .complete_en_i       (complete_en_i),
    .complete_idx_i      (complete_idx_i),
    .rollback_en_i       (rollback_en_i),
    .rollback_idx_i      (rollback_idx_i),
    .retire_en_o         (retire_en_o),
    .retire_dest_idx_o   (retire_dest_idx_o),
    .retire_T_idx_o      (retire_T_idx_o),
    .retire_Told_idx_o   (retire_Told_idx_o),
    .halt_out_o          (halt_out_o)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_retired_o      (perf_retired_o),
    .perf_full_stall_o   (perf_full_stall_o),
    .perf_squashed_o     (perf_squashed_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [AR_W-1:0] d;
    logic [PR_W-1:0] t;
    logic [PR_W-1:0] to;
  } rec_t;

  rec_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dispatch_en_i   = '0;
    dispatch_halt_i = '0;
    complete_en_i   = '0;
    complete_idx_i  = '0;
    rollback_en_i   = 1'b0;
    rollback_idx_i  = '0;
  endtask

  // Compare retiring lanes against the program-order queue, then advance to the next negedge
  task automatic step();
    rec_t got;
    rec_t exp;
    #1;
    for (int j = 0; j < RETIRE_W; j++) begin
      if (retire_en_o[j]) begin
        got = {retire_dest_idx_o[j*AR_W +: AR_W], retire_T_idx_o[j*PR_W +: PR_W],
               retire_Told_idx_o[j*PR_W +: PR_W]};
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp = sb_q.pop_front();
          check_eq("retire_data", 32'(got), 32'(exp));
        end
      end
    end
    @(negedge clock_i);
  endtask

  task automatic set_disp(input logic [1:0] m, input logic [1:0] h, input bit push);
    rec_t r;
    dispatch_en_i   = m;
    dispatch_halt_i = h;
    for (int i = 0; i < DISPATCH_W; i++) begin
      r.d  = AR_W'($urandom);
      r.t  = PR_W'($urandom);
      r.to = PR_W'($urandom);
      dispatch_dest_idx_i[i*AR_W +: AR_W] = r.d;
      dispatch_T_idx_i[i*PR_W +: PR_W]    = r.t;
      dispatch_Told_idx_i[i*PR_W +: PR_W] = r.to;
      if (push && m[i]) sb_q.push_back(r);
    end
  endtask

  task automatic set_comp(input logic [1:0] m, input int a, input int b);
    complete_en_i  = m;
    complete_idx_i = {IDX_W'(b), IDX_W'(a)};
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    en_i    = 1'b1;
    idle();
    sb_q.delete();
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) step();
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    en_i    = 1'b1;
    idle();
    dispatch_dest_idx_i = '0;
    dispatch_T_idx_i    = '0;
    dispatch_Told_idx_i = '0;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_retire_en", 32'(retire_en_o), 32'd0);
    check_eq("rst_halt_out", 32'(halt_out_o), 32'd0);
    check_eq("rst_free_slots", 32'(free_slots_o), 32'd32);
    check_eq("rst_dispatch_ready", 32'(dispatch_ready_o), 32'd1);
    step();

    // Fill to full, then drain with wrap
    for (int c = 0; c < 16; c++) begin
      set_disp(2'b11, 2'b00, 1'b1);
      #1;
      check_eq("fill_rob_idx", 32'(ROB_idx_o), 32'(((2*c+1) << IDX_W) | (2*c)));
      check_eq("fill_ready", 32'(dispatch_ready_o), 32'd1);
      step();
    end
    set_disp(2'b11, 2'b00, 1'b0);
    #1;
    check_eq("full_free_slots", 32'(free_slots_o), 32'd0);
    check_eq("full_ready", 32'(dispatch_ready_o), 32'd0);
    check_eq("full_rob_idx", 32'(ROB_idx_o), 32'((1 << IDX_W) | 0));
    step();
    #1;
    check_eq("full_rob_idx_hold", 32'(ROB_idx_o), 32'((1 << IDX_W) | 0));
    check_eq("full_free_hold", 32'(free_slots_o), 32'd0);
    step();
    idle();
    for (int c = 0; c < 16; c++) begin
      set_comp(2'b11, 2*c, 2*c+1);
      step();
    end
    idle();
    drain("fill_drain");
    #1;
    check_eq("fill_empty_free", 32'(free_slots_o), 32'd32);

    // Out-of-order completion, in-order retire
    do_reset();
    set_disp(2'b11, 2'b00, 1'b1); step();
    set_disp(2'b11, 2'b00, 1'b1); step();
    idle();
    set_comp(2'b11, 1, 0); step();
    set_comp(2'b01, 3, 0);
    #1;
    check_eq("ooo_retire_01", 32'(retire_en_o), 32'd3);
    step();
    idle();
    #1;
    check_eq("ooo_blocked", 32'(retire_en_o), 32'd0);
    check_eq("ooo_free", 32'(free_slots_o), 32'd30);
    step();
    set_comp(2'b01, 2, 0); step();
    idle();
    #1;
    check_eq("ooo_retire_23", 32'(retire_en_o), 32'd3);
    step();
    drain("ooo_drain");

    // Rollback with same-cycle completion to a squashed entry and blocked dispatch
    do_reset();
    for (int c = 0; c < 3; c++) begin set_disp(2'b11, 2'b00, 1'b1); step(); end
    idle();
    rollback_en_i  = 1'b1;
    rollback_idx_i = IDX_W'(2);
    set_comp(2'b01, 4, 0);
    set_disp(2'b11, 2'b00, 1'b0);
    #1;
    check_eq("rb_ready_blocked", 32'(dispatch_ready_o), 32'd0);
    step();
    idle();
    for (int s = 0; s < 3; s++) void'(sb_q.pop_back());
    #1;
    check_eq("rb_free", 32'(free_slots_o), 32'd29);
    check_eq("rb_tail", 32'(ROB_idx_o), 32'((4 << IDX_W) | 3));
    step();
    set_comp(2'b11, 0, 1); step();
    set_comp(2'b01, 2, 0); step();
    idle();
    drain("rb_drain");
    #1;
    check_eq("rb_empty_free", 32'(free_slots_o), 32'd32);

    // Wrap rollback: head=30, tail=4, branch at 31
    do_reset();
    for (int c = 0; c < 15; c++) begin set_disp(2'b11, 2'b00, 1'b1); step(); end
    idle();
    for (int c = 0; c < 15; c++) begin set_comp(2'b11, 2*c, 2*c+1); step(); end
    idle();
    drain("wrap_pre_drain");
    for (int c = 0; c < 3; c++) begin set_disp(2'b11, 2'b00, 1'b1); step(); end
    idle();
    #1;
    check_eq("wrap_free_pre", 32'(free_slots_o), 32'd26);
    check_eq("wrap_tail_pre", 32'(ROB_idx_o), 32'((5 << IDX_W) | 4));
    rollback_en_i  = 1'b1;
    rollback_idx_i = IDX_W'(31);
    step();
    idle();
    for (int s = 0; s < 4; s++) void'(sb_q.pop_back());
    #1;
    check_eq("wrap_free_post", 32'(free_slots_o), 32'd30);
    check_eq("wrap_tail_post", 32'(ROB_idx_o), 32'((1 << IDX_W) | 0));
    step();
    set_comp(2'b11, 30, 31); step();
    idle();
    #1;
    check_eq("wrap_retire", 32'(retire_en_o), 32'd3);
    step();
    drain("wrap_drain");

    // Halt stops the group and freezes the ROB
    do_reset();
    set_disp(2'b11, 2'b01, 1'b1); step();
    idle();
    set_comp(2'b11, 0, 1); step();
    idle();
    #1;
    check_eq("halt_retire_en", 32'(retire_en_o), 32'd1);
    check_eq("halt_out", 32'(halt_out_o), 32'd1);
    step();
    #1;
    check_eq("halted_retire_en", 32'(retire_en_o), 32'd0);
    check_eq("halted_halt_out", 32'(halt_out_o), 32'd0);
    check_eq("halted_ready", 32'(dispatch_ready_o), 32'd0);
    step();
    set_comp(2'b01, 1, 0); step();
    idle();
    #1;
    check_eq("halted_no_retire", 32'(retire_en_o), 32'd0);
    step();
    check_eq("halted_sb_left", 32'(sb_q.size()), 32'd1);

    // Asynchronous reset in the middle of a rollback cycle
    do_reset();
    for (int c = 0; c < 5; c++) begin set_disp(2'b11, 2'b00, 1'b1); step(); end
    idle();
    set_comp(2'b11, 0, 1); step();
    idle();
    rollback_en_i  = 1'b1;
    rollback_idx_i = IDX_W'(3);
    #1;
    check_eq("arst_pre_retire", 32'(retire_en_o), 32'd3);
    check_eq("arst_pre_free", 32'(free_slots_o), 32'd22);
    #1;
    reset_i = 1'b1;
    #1;
    check_eq("arst_retire_en", 32'(retire_en_o), 32'd0);
    check_eq("arst_free", 32'(free_slots_o), 32'd32);
    check_eq("arst_halt_out", 32'(halt_out_o), 32'd0);
    idle();
    @(negedge clock_i);
    reset_i = 1'b0;
    sb_q.delete();
    @(negedge clock_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
